prog_mem: RTL
=============

Name: prog_mem

Overview:
- Program memory that answers the CPU's instruction/data fetch: CPU drives memAddr, this block returns memVal.
- Adds a byte-stream load port with a valid/ready handshake, so a host or boot loader can write a program into the array.
- Asserts cpuHold while loading, so the CPU top level can hold the core in reset until the image is complete.

Parameters:
- ADDR_W, 8, address width; array depth is 2**ADDR_W.
- DATA_W, 8, data width of memVal and ldData.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- memAddr  input  ADDR_W  fetch address from the CPU control unit.
- memVal  output  DATA_W  fetched byte returned to the CPU.
- ldStart  input  1  request to begin a load; sampled only in IDLE.
- ldBase  input  ADDR_W  first write address; captured with ldStart.
- ldLen  input  ADDR_W  byte count, captured with ldStart; 0 means 2**ADDR_W bytes.
- ldData  input  DATA_W  load byte.
- ldValid  input  1  ldData is valid.
- ldReady  output  1  block accepts a byte this cycle.
- ldDone  output  1  one-cycle pulse after the last byte is written.
- cpuHold  output  1  CPU must be held in reset.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; write pointer=0; remaining count=0.
  - ldReady=0, ldDone=0, cpuHold=0.
  - Array contents are not cleared; unwritten locations read as undefined.
- Read path: memVal = mem[memAddr], combinational, zero latency, in IDLE and DONE.
  - In LOAD, memVal is forced to 0 so the held CPU never sees partial data.
- States IDLE, LOAD, DONE.
  - IDLE: ldStart=1 at a clock edge captures ptr<=ldBase and rem<=ldLen (0 loads as 2**ADDR_W, using an ADDR_W+1-bit counter), then goes to LOAD.
  - LOAD: ldReady=1 and cpuHold=1.
    - Transfer occurs on an edge with ldValid&&ldReady: mem[ptr]<=ldData, ptr<=ptr+1 (mod 2**ADDR_W wrap), rem<=rem-1.
    - A transfer with rem==1 moves to DONE.
    - ldValid=0 stalls indefinitely with no timeout; ldStart is ignored.
  - DONE (exactly one cycle): ldDone=1, cpuHold=1, ldReady=0; next state is IDLE.
- cpuHold first asserts in the cycle after ldStart is accepted. It deasserts in the cycle after DONE, when memVal already reflects the new image.
- Boundary conditions:
  - ldStart asserted in LOAD or DONE: ignored; a new load needs IDLE.
  - ldLen=0: full-array load of 2**ADDR_W bytes; ptr wraps back to ldBase.
  - ldBase+ldLen past the top address: writes wrap to address 0 onward.
  - Read of the address being written in the same cycle: not visible, since memVal is forced to 0 in LOAD.
  - Reset mid-LOAD: returns to IDLE with cpuHold=0 and ldReady=0 immediately. Bytes already written are retained; later bytes are not written. No ldDone is produced.
  - ldValid with ldReady=0 (IDLE/DONE): byte is dropped, with no side effects.

Test Plan:
- Reset then idle read: assert rst, release, memAddr=0x10 -> ldReady=0, cpuHold=0, ldDone=0.
- Basic load: ldStart with ldBase=0x00, ldLen=4, ldValid continuous, bytes A0,A1,A2,A3 -> 4 accept cycles, then a 1-cycle ldDone with cpuHold=1, then cpuHold=0. memAddr=0..3 reads A0..A3; memVal=0 throughout LOAD.
- Stalled handshake: ldLen=3, ldValid toggled 1,0,0,1,0,1 with 11,22,33 -> only 3 writes; ldDone arrives 1 cycle after the 6th cycle; mem[base..base+2]=11,22,33.
- Wrap and full length: ldBase=0xFE, ldLen=3 with 01,02,03 -> mem[FE]=01, mem[FF]=02, mem[00]=03. Separately, ldLen=0 gives exactly 256 accepts before ldDone.
- Ignored start: pulse ldStart mid-load with a different ldBase/ldLen -> the load completes with the original parameters.
- Reset mid-load: ldLen=8, assert rst after 3 accepts -> ldReady and cpuHold drop without a clock edge. After release, the first 3 bytes are readable, byte 4's location is unchanged, and ldDone never pulses.

Source files
------------

// File: rtl/prog_mem_if.sv
// Fetch port and byte-stream load port of the program memory.
// master = CPU/boot-loader side, slave = memory side.
interface prog_mem_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memVal;
   logic              ldStart;
   logic [ADDR_W-1:0] ldBase;
   logic [ADDR_W-1:0] ldLen;
   logic [DATA_W-1:0] ldData;
   logic              ldValid;
   logic              ldReady;
   logic              ldDone;
   logic              cpuHold;

   modport master (
      output memAddr, ldStart, ldBase, ldLen, ldData, ldValid,
      input  memVal, ldReady, ldDone, cpuHold
   );

   modport slave (
      input  memAddr, ldStart, ldBase, ldLen, ldData, ldValid,
      output memVal, ldReady, ldDone, cpuHold
   );
endinterface

// File: rtl/prog_mem.sv
// Program memory with combinational fetch and a valid/ready byte loader.
// The CPU is held while an image is streamed in; reads return 0 during the load.
module prog_mem #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input logic       clk,
   input logic       rst,
   prog_mem_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t            state, stateNext;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   rem;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic              xfer;

   // state is forced to IDLE asynchronously, so no write can slip in during reset
   assign xfer = (state == LOAD) && bus.ldValid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.ldStart) stateNext = LOAD;
         LOAD:    if (xfer && rem == (ADDR_W+1)'(1)) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
         rem <= '0;
      end else if (state == IDLE && bus.ldStart) begin
         ptr <= bus.ldBase;
         // a length of 0 sets only the top bit: a full 2**ADDR_W byte load
         rem <= {(bus.ldLen == '0), bus.ldLen};
      end else if (xfer) begin
         ptr <= ptr + ADDR_W'(1);
         rem <= rem - (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (xfer) mem[ptr] <= bus.ldData;
   end

   assign bus.ldReady = (state == LOAD);
   assign bus.ldDone  = (state == DONE);
   assign bus.cpuHold = (state != IDLE);
   assign bus.memVal  = (state == LOAD) ? '0 : mem[bus.memAddr];
endmodule
